mcse_bus_arbiter: RTL and testbench

MCSE_BUS_ARBITER -- requirements
Module: mcse_bus_arbiter

---
 rtl/mcse_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mcse_bus_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcse_bus_arbiter.sv
// Two-requester (boot control, firmware loader) round-robin arbiter issuing
// single-word AHB transfers, with a per-transfer hready wait timeout.
module mcse_bus_arbiter #(
  parameter int pAHB_ADDR_WIDTH = 32,
  parameter int pAHB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       boot_go,
  input  logic [pAHB_ADDR_WIDTH-1:0] boot_addr,
  input  logic [pAHB_DATA_WIDTH-1:0] boot_wdata,
  input  logic                       boot_rw,
  output logic                       boot_done,
  output logic [pAHB_DATA_WIDTH-1:0] boot_rdata,
  output logic                       boot_err,
  input  logic                       fw_go,
  input  logic [pAHB_ADDR_WIDTH-1:0] fw_addr,
  input  logic [pAHB_DATA_WIDTH-1:0] fw_wdata,
  input  logic                       fw_rw,
  output logic                       fw_done,
  output logic [pAHB_DATA_WIDTH-1:0] fw_rdata,
  output logic                       fw_err,
  input  logic [pAHB_DATA_WIDTH-1:0] I_hrdata,
  input  logic                       I_hready,
  input  logic [1:0]                 I_hresp,
  output logic [pAHB_ADDR_WIDTH-1:0] O_haddr,
  output logic [2:0]                 O_hburst,
  output logic                       O_hmastlock,
  output logic [3:0]                 O_hprot,
  output logic                       O_hnonsec,
  output logic [2:0]                 O_hsize,
  output logic [1:0]                 O_htrans,
  output logic [pAHB_DATA_WIDTH-1:0] O_hwdata,
  output logic                       O_hwrite,
  output logic                       busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic                         r_grant_fw;
  logic                         r_last_fw;
  logic [pAHB_ADDR_WIDTH-1:0]   r_addr;
  logic [pAHB_DATA_WIDTH-1:0]   r_wdata;
  logic                         r_rw;
  logic [CW-1:0]                r_wait_cnt;
  logic                         r_boot_done, r_boot_err, r_fw_done, r_fw_err;
  logic [pAHB_DATA_WIDTH-1:0]   r_boot_rdata, r_fw_rdata;

  logic                         w_in_xfer;
  logic                         w_timeout;
  logic                         w_grant_fw;
  logic                         w_enter_done;
  logic                         w_cpl_err;
  logic [pAHB_DATA_WIDTH-1:0]   w_cpl_rdata;

  // r_last_fw resets to 1 so that a simultaneous first request goes to boot.
  assign w_grant_fw   = fw_go & (~boot_go | ~r_last_fw);
  assign w_in_xfer    = (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_timeout    = w_in_xfer & ~I_hready & (r_wait_cnt == CNT_LAST);
  assign w_enter_done = (r_state != ST_DONE) && (w_next == ST_DONE);
  assign w_cpl_err    = w_timeout | (I_hresp != 2'b00);
  assign w_cpl_rdata  = (w_cpl_err | r_rw) ? {pAHB_DATA_WIDTH{1'b0}} : I_hrdata;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = (boot_go | fw_go) ? ST_ADDR : ST_IDLE;
      ST_ADDR: begin
        if (I_hready)       w_next = ST_DATA;
        else if (w_timeout) w_next = ST_DONE;
        else                w_next = ST_ADDR;
      end
      ST_DATA: w_next = (I_hready | w_timeout) ? ST_DONE : ST_DATA;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Bus-side outputs decoded from the state register
  always_comb begin
    busy     = 1'b0;
    O_htrans = 2'b00;
    O_hwrite = 1'b0;
    case (r_state)
      ST_IDLE: busy = 1'b0;
      ST_ADDR: begin
        busy     = 1'b1;
        O_htrans = 2'b10;
        O_hwrite = r_rw;
      end
      ST_DATA: busy = 1'b1;
      ST_DONE: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign O_haddr     = r_addr;
  assign O_hwdata    = r_wdata;
  assign O_hburst    = 3'b000;
  assign O_hsize     = 3'b010;
  assign O_hprot     = 4'b0011;
  assign O_hmastlock = 1'b0;
  assign O_hnonsec   = 1'b0;

  // Request capture, round-robin history and hready wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_fw <= 1'b0;
      r_last_fw  <= 1'b1;
      r_addr     <= {pAHB_ADDR_WIDTH{1'b0}};
      r_wdata    <= {pAHB_DATA_WIDTH{1'b0}};
      r_rw       <= 1'b0;
      r_wait_cnt <= {CW{1'b0}};
    end else begin
      if ((r_state == ST_IDLE) && (boot_go | fw_go)) begin
        r_grant_fw <= w_grant_fw;
        r_addr     <= w_grant_fw ? fw_addr  : boot_addr;
        r_wdata    <= w_grant_fw ? fw_wdata : boot_wdata;
        r_rw       <= w_grant_fw ? fw_rw    : boot_rw;
      end
      if (r_state == ST_DONE) begin
        r_last_fw <= r_grant_fw;
      end
      if (w_next != r_state) begin
        r_wait_cnt <= {CW{1'b0}};
      end else if (w_in_xfer && !I_hready && (r_wait_cnt != CNT_MAX)) begin
        r_wait_cnt <= r_wait_cnt + CW'(1);
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
    end
  end

  // Completion outputs: done/err live only during DONE, rdata holds until next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_boot_done  <= 1'b0;
      r_boot_err   <= 1'b0;
      r_boot_rdata <= {pAHB_DATA_WIDTH{1'b0}};
      r_fw_done    <= 1'b0;
      r_fw_err     <= 1'b0;
      r_fw_rdata   <= {pAHB_DATA_WIDTH{1'b0}};
    end else begin
      r_boot_done <= w_enter_done & ~r_grant_fw;
      r_boot_err  <= w_enter_done & ~r_grant_fw & w_cpl_err;
      r_fw_done   <= w_enter_done & r_grant_fw;
      r_fw_err    <= w_enter_done & r_grant_fw & w_cpl_err;
      if (w_enter_done && !r_grant_fw) begin
        r_boot_rdata <= w_cpl_rdata;
      end
      if (w_enter_done && r_grant_fw) begin
        r_fw_rdata <= w_cpl_rdata;
      end
    end
  end

  assign boot_done  = r_boot_done;
  assign boot_err   = r_boot_err;
  assign boot_rdata = r_boot_rdata;
  assign fw_done    = r_fw_done;
  assign fw_err     = r_fw_err;
  assign fw_rdata   = r_fw_rdata;

endmodule

// File: tb/tb_mcse_bus_arbiter.sv
// Scoreboard bench for mcse_bus_arbiter: scripted AHB slave, completions
// checked against queued expectations including the completion cycle.
module tb_mcse_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        boot_go = 1'b0, boot_rw = 1'b0, fw_go = 1'b0, fw_rw = 1'b0;
  logic [31:0] boot_addr = 32'h0, boot_wdata = 32'h0, fw_addr = 32'h0, fw_wdata = 32'h0;
  logic        boot_done, boot_err, fw_done, fw_err;
  logic [31:0] boot_rdata, fw_rdata;
  logic [31:0] I_hrdata = 32'h0;
  logic        I_hready = 1'b1;
  logic [1:0]  I_hresp = 2'b00;
  logic [31:0] O_haddr, O_hwdata;
  logic [2:0]  O_hburst, O_hsize;
  logic        O_hmastlock, O_hnonsec, O_hwrite, busy;
  logic [3:0]  O_hprot;
  logic [1:0]  O_htrans;

  mcse_bus_arbiter #(.pAHB_ADDR_WIDTH(32), .pAHB_DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .boot_go(boot_go), .boot_addr(boot_addr), .boot_wdata(boot_wdata), .boot_rw(boot_rw),
    .boot_done(boot_done), .boot_rdata(boot_rdata), .boot_err(boot_err),
    .fw_go(fw_go), .fw_addr(fw_addr), .fw_wdata(fw_wdata), .fw_rw(fw_rw),
    .fw_done(fw_done), .fw_rdata(fw_rdata), .fw_err(fw_err),
    .I_hrdata(I_hrdata), .I_hready(I_hready), .I_hresp(I_hresp),
    .O_haddr(O_haddr), .O_hburst(O_hburst), .O_hmastlock(O_hmastlock), .O_hprot(O_hprot),
    .O_hnonsec(O_hnonsec), .O_hsize(O_hsize), .O_htrans(O_htrans), .O_hwdata(O_hwdata),
    .O_hwrite(O_hwrite), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fw;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] hold_rd [2];
  bit          last_fw = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Completion monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (boot_done && fw_done) begin
        check_eq("dual_done", 32'd1, 32'd0);
      end else if (boot_done || fw_done) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("done_who",  {31'd0, fw_done}, {31'd0, e.fw});
          check_eq("done_rdata", fw_done ? fw_rdata : boot_rdata, e.rdata);
          check_eq("done_err",  {31'd0, fw_done ? fw_err : boot_err}, {31'd0, e.err});
          check_eq("done_cycle", 32'(cyc), 32'(e.cyc));
          check_eq("other_err", {31'd0, fw_done ? boot_err : fw_err}, 32'd0);
          check_eq("other_rdata_hold", fw_done ? boot_rdata : fw_rdata, hold_rd[fw_done ? 0 : 1]);
          hold_rd[fw_done ? 1 : 0] = e.rdata;
        end
      end
    end
  end

  // One transfer, started and ended at a negedge with the DUT in IDLE
  task automatic xfer(input bit win_fw, input bit both, input bit keep,
                      input logic [31:0] addr, input logic [31:0] wdata, input bit rw,
                      input logic [31:0] rdat, input logic [1:0] resp,
                      input int aw, input int dw);
    exp_t e;
    bit   to_a, to_d;
    int   c;
    c     = cyc;
    to_a  = (aw >= TO);
    to_d  = !to_a && (dw >= TO);
    e.fw  = win_fw;
    e.err = to_a || to_d || (resp != 2'b00);
    e.rdata = (e.err || rw) ? 32'h0 : rdat;
    e.cyc = to_a ? c + 1 + TO : (to_d ? c + 2 + aw + TO : c + 3 + aw + dw);
    sb.push_back(e);
    if (win_fw) begin
      fw_go = 1'b1; fw_addr = addr; fw_wdata = wdata; fw_rw = rw;
      boot_go = both; boot_addr = ~addr; boot_wdata = ~wdata; boot_rw = ~rw;
    end else begin
      boot_go = 1'b1; boot_addr = addr; boot_wdata = wdata; boot_rw = rw;
      fw_go = both; fw_addr = ~addr; fw_wdata = ~wdata; fw_rw = ~rw;
    end
    I_hready = 1'b1; I_hresp = 2'b00; I_hrdata = 32'h0;
    @(negedge clk);
    if (!keep) begin
      boot_go = 1'b0; fw_go = 1'b0;
    end
    check_eq("htrans_addr", {30'd0, O_htrans}, 32'h2);
    check_eq("haddr", O_haddr, addr);
    check_eq("hwrite", {31'd0, O_hwrite}, {31'd0, rw});
    for (int n = 0; n < aw && n < TO; n++) begin
      I_hready = 1'b0;
      @(negedge clk);
    end
    if (!to_a) begin
      I_hready = 1'b1;
      @(negedge clk);
      I_hrdata = rdat; I_hresp = resp;
      check_eq("htrans_data", {30'd0, O_htrans}, 32'h0);
      check_eq("hwdata", O_hwdata, wdata);
      for (int n = 0; n < dw && n < TO; n++) begin
        I_hready = 1'b0;
        check_eq("hwdata_wait", O_hwdata, wdata);
        @(negedge clk);
      end
      if (!to_d) begin
        I_hready = 1'b1;
        @(negedge clk);
      end
    end
    check_eq("htrans_done", {30'd0, O_htrans}, 32'h0);
    check_eq("busy_done", {31'd0, busy}, 32'd1);
    I_hready = 1'b1; I_hresp = 2'b00; I_hrdata = 32'h0;
    @(negedge clk);
    last_fw = win_fw;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check_eq({tag, "_htrans"}, {30'd0, O_htrans}, 32'd0);
    check_eq({tag, "_dones"}, {30'd0, boot_done, fw_done}, 32'd0);
    check_eq({tag, "_errs"},  {30'd0, boot_err, fw_err}, 32'd0);
    check_eq({tag, "_rdata"}, boot_rdata | fw_rdata, 32'd0);
    check_eq({tag, "_haddr"}, O_haddr, 32'd0);
    check_eq({tag, "_hwdata"}, O_hwdata, 32'd0);
    check_eq({tag, "_hwrite"}, {31'd0, O_hwrite}, 32'd0);
    check_eq({tag, "_consts"}, {19'd0, O_hburst, O_hsize, O_hprot, O_hmastlock, O_hnonsec},
             {19'd0, 3'b000, 3'b010, 4'b0011, 1'b0, 1'b0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit b, f, wf;
    hold_rd[0] = 32'h0; hold_rd[1] = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("post_rst");

    // boot read, zero waits
    xfer(1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 32'hDEAD_BEEF, 2'b00, 0, 0);
    // fw write, two data-phase waits
    xfer(1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'hA5A5_A5A5, 1'b1, 32'h1234_5678, 2'b00, 0, 2);
    // fw read with error response
    xfer(1'b1, 1'b0, 1'b0, 32'h0000_2004, 32'h0, 1'b0, 32'hCAFE_F00D, 2'b01, 1, 0);
    // timeout in data phase, then in address phase
    xfer(1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h0, 1'b0, 32'h5555_AAAA, 2'b00, 0, TO);
    xfer(1'b0, 1'b0, 1'b0, 32'h0000_3004, 32'h0, 1'b1, 32'h0, 2'b00, TO, 0);
    // one wait short of timeout in both phases
    xfer(1'b1, 1'b0, 1'b0, 32'h0000_4000, 32'h0, 1'b0, 32'h0BAD_CAFE, 2'b00, TO - 1, TO - 1);

    for (int i = 0; i < 8; i++) begin
      b = 1'($urandom_range(0, 1));
      f = 1'($urandom_range(0, 1));
      if (!b && !f) b = 1'b1;
      wf = (b && f) ? !last_fw : f;
      xfer(wf, b && f, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
           ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00,
           $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // make fw the last grant, then both held through three transfers
    xfer(1'b1, 1'b0, 1'b0, 32'h0000_5000, 32'h0, 1'b0, 32'h1111_1111, 2'b00, 0, 0);
    xfer(1'b0, 1'b1, 1'b1, 32'h0000_6000, 32'h0, 1'b0, 32'h2222_2222, 2'b00, 0, 0);
    xfer(1'b1, 1'b1, 1'b1, 32'h0000_6004, 32'h0, 1'b0, 32'h3333_3333, 2'b00, 0, 1);
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_6008, 32'h0, 1'b0, 32'h4444_4444, 2'b00, 1, 0);

    // reset during the data phase of a boot transfer
    boot_go = 1'b1; boot_addr = 32'h0000_7000; boot_rw = 1'b0;
    @(negedge clk);
    boot_go = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
    I_hready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_htrans", {30'd0, O_htrans}, 32'd0);
    hold_rd[0] = 32'h0; hold_rd[1] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    I_hready = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_state("after_abort");
    last_fw = 1'b1;
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_8000, 32'h0, 1'b0, 32'h7777_7777, 2'b00, 0, 0);
    xfer(1'b1, 1'b1, 1'b0, 32'h0000_8004, 32'h0, 1'b0, 32'h8888_8888, 2'b00, 0, 0);

    repeat (3) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
